// File: rtl/tof_serial_timer_if.sv
`default_nettype none
//==============================================================================
// Module   : tof_serial_timer_if
// Brief    : Two-wire toggle handshake between the TOF timer and the Arduino.
// Revision : 1.0 - initial release
//==============================================================================
interface tof_serial_timer_if;
    logic req_toggle;
    logic data_bit;
    logic ack_toggle;

    // master = timer side (drives data), slave = Arduino side (acknowledges)
    modport master (output req_toggle, output data_bit, input ack_toggle);
    modport slave  (input req_toggle, input data_bit, output ack_toggle);
endinterface
`default_nettype wire

// File: rtl/tof_serial_timer.sv
`default_nettype none
//==============================================================================
// Module   : tof_serial_timer
// Brief    : LoRa time-of-flight timer with hold-off, saturating counter and
//            LSB-first toggle-handshake readout. Define TOF_TIMEOUT_EN to
//            enable the missing-echo timeout.
// Revision : 1.0 - initial release
//==============================================================================
module tof_serial_timer #(
    parameter int CNT_W   = 32,
    parameter int HOLDOFF = 10000000,
    parameter int TIMEOUT = 50000000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               tx_n,
    input  logic               abort,
    tof_serial_timer_if.master link,
    output logic [CNT_W-1:0]   tof_value,
    output logic               tof_valid,
    output logic               timeout_flag,
    output logic               busy,
    output logic               led_armed,
    output logic               led_holdoff,
    output logic               led_echo,
    output logic               led_sent
);

    if (HOLDOFF < 1 || TIMEOUT < 1 || CNT_W < 2) begin : g_bad_params
        $error("tof_serial_timer: CNT_W must be >= 2, HOLDOFF and TIMEOUT >= 1");
    end

    localparam int c_HO_W  = $clog2(HOLDOFF + 1);
    localparam int c_BIT_W = $clog2(CNT_W + 1);

    localparam logic [c_HO_W-1:0]  c_HOLD_INIT = c_HO_W'(HOLDOFF);
    localparam logic [c_HO_W-1:0]  c_HOLD_ONE  = c_HO_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(CNT_W);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
`ifdef TOF_TIMEOUT_EN
    localparam logic [CNT_W-1:0]   c_TIMEOUT_CNT = CNT_W'(TIMEOUT);
`endif

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ARM       = 3'd1;
    localparam logic [2:0] c_HOLDOFF   = 3'd2;
    localparam logic [2:0] c_WAIT_ECHO = 3'd3;
    localparam logic [2:0] c_SEND      = 3'd4;
    localparam logic [2:0] c_DONE      = 3'd5;

    logic               r_tx_meta, r_tx_sync, r_tx_prev;
    logic               r_ack_meta, r_ack_sync;
    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_HO_W-1:0]  r_hold;
    logic [c_BIT_W-1:0] r_bits;
    logic [CNT_W-1:0]   r_shift;
    logic [CNT_W-1:0]   r_tof;
    logic               r_req, r_data_bit, r_tof_valid, r_timeout, r_busy;
    logic               r_led_armed, r_led_holdoff, r_led_echo, r_led_sent;

    logic               w_tx_fall;
    logic [CNT_W-1:0]   w_cnt_inc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_tx_meta  <= 1'b1;
            r_tx_sync  <= 1'b1;
            r_tx_prev  <= 1'b1;
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_tx_meta  <= tx_n;
            r_tx_sync  <= r_tx_meta;
            r_tx_prev  <= r_tx_sync;
            r_ack_meta <= link.ack_toggle;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_tx_fall = r_tx_prev & ~r_tx_sync;
    // Both edges are seen through the same pipeline, so the value captured on
    // the echo cycle is the incremented count: it equals the pin interval.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + c_CNT_ONE;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_bits        <= '0;
            r_shift       <= '0;
            r_tof         <= '0;
            r_req         <= 1'b0;
            r_data_bit    <= 1'b0;
            r_tof_valid   <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            r_led_armed   <= 1'b0;
            r_led_holdoff <= 1'b0;
            r_led_echo    <= 1'b0;
            r_led_sent    <= 1'b0;
        end else if (abort) begin
            // req_toggle keeps its level so the Arduino stays in phase
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_bits        <= '0;
            r_shift       <= '0;
            r_tof         <= '0;
            r_data_bit    <= 1'b0;
            r_tof_valid   <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            r_led_armed   <= 1'b0;
            r_led_holdoff <= 1'b0;
            r_led_echo    <= 1'b0;
            r_led_sent    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state       <= c_ARM;
                        r_cnt         <= '0;
                        r_tof         <= '0;
                        r_data_bit    <= 1'b0;
                        r_tof_valid   <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_led_armed   <= 1'b1;
                        r_led_holdoff <= 1'b0;
                        r_led_echo    <= 1'b0;
                        r_led_sent    <= 1'b0;
                    end
                end
                c_ARM: begin
                    if (w_tx_fall) begin
                        r_state <= c_HOLDOFF;
                        r_cnt   <= '0;
                        r_hold  <= c_HOLD_INIT;
                    end
                end
                c_HOLDOFF: begin
                    r_cnt  <= w_cnt_inc;
                    r_hold <= r_hold - c_HOLD_ONE;
                    if (r_hold == c_HOLD_ONE) begin
                        r_state       <= c_WAIT_ECHO;
                        r_led_holdoff <= 1'b1;
                    end
                end
                c_WAIT_ECHO: begin
                    r_cnt <= w_cnt_inc;
                    if (w_tx_fall) begin
                        r_state     <= c_SEND;
                        r_tof       <= w_cnt_inc;
                        r_led_echo  <= 1'b1;
                        r_led_armed <= 1'b0;
                        r_data_bit  <= w_cnt_inc[0];
                        r_shift     <= w_cnt_inc >> 1;
                        r_req       <= ~r_req;
                        r_bits      <= c_BIT_ONE;
                    end
`ifdef TOF_TIMEOUT_EN
                    else if (r_cnt == c_TIMEOUT_CNT) begin
                        r_state     <= c_SEND;
                        r_tof       <= '1;
                        r_timeout   <= 1'b1;
                        r_led_armed <= 1'b0;
                        r_data_bit  <= 1'b1;
                        r_shift     <= '1;
                        r_req       <= ~r_req;
                        r_bits      <= c_BIT_ONE;
                    end
`endif
                end
                c_SEND: begin
                    if (r_ack_sync == r_req) begin
                        if (r_bits == c_BIT_LAST) begin
                            r_state     <= c_DONE;
                            r_busy      <= 1'b0;
                            r_tof_valid <= 1'b1;
                            r_led_sent  <= 1'b1;
                        end else begin
                            r_data_bit <= r_shift[0];
                            r_shift    <= r_shift >> 1;
                            r_req      <= ~r_req;
                            r_bits     <= r_bits + c_BIT_ONE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign link.req_toggle = r_req;
    assign link.data_bit   = r_data_bit;
    assign tof_value       = r_tof;
    assign tof_valid       = r_tof_valid;
    assign timeout_flag    = r_timeout;
    assign busy            = r_busy;
    assign led_armed       = r_led_armed;
    assign led_holdoff     = r_led_holdoff;
    assign led_echo        = r_led_echo;
    assign led_sent        = r_led_sent;

endmodule
`default_nettype wire

// File: tb/tb_tof_serial_timer.sv
`default_nettype none
//==============================================================================
// Module   : tb_tof_serial_timer
// Brief    : Scoreboard bench for tof_serial_timer with a random-latency
//            Arduino acknowledge model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_tof_serial_timer;
    localparam int CNT_W   = 16;
    localparam int HOLDOFF = 8;
    localparam int TIMEOUT = 100;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             tx_n;
    logic             abort;
    logic [CNT_W-1:0] tof_value;
    logic             tof_valid, timeout_flag, busy;
    logic             led_armed, led_holdoff, led_echo, led_sent;

    tof_serial_timer_if link ();

    tof_serial_timer #(
        .CNT_W  (CNT_W),
        .HOLDOFF(HOLDOFF),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .tx_n        (tx_n),
        .abort       (abort),
        .link        (link),
        .tof_value   (tof_value),
        .tof_valid   (tof_valid),
        .timeout_flag(timeout_flag),
        .busy        (busy),
        .led_armed   (led_armed),
        .led_holdoff (led_holdoff),
        .led_echo    (led_echo),
        .led_sent    (led_sent)
    );

    int n_pass  = 0;
    int n_total = 0;

    // expected word: {timeout_flag, tof_value}
    logic [CNT_W:0]   sb[$];
    logic [CNT_W:0]   mon_exp;
    logic             mon_prev_valid;
    int               rx_count;
    logic [CNT_W-1:0] word_rx;
    logic             ard_last_req;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Arduino: sample the bit on each req toggle, ack after 0-20 cycles.
    initial begin : arduino
        link.ack_toggle = 1'b0;
        ard_last_req    = 1'b0;
        rx_count        = 0;
        word_rx         = '0;
        forever begin
            @(negedge clock);
            if (led_armed) begin
                rx_count = 0;
                word_rx  = '0;
            end else if (link.req_toggle !== ard_last_req) begin
                ard_last_req = link.req_toggle;
                word_rx      = {link.data_bit, word_rx[CNT_W-1:1]};
                rx_count++;
                repeat ($urandom_range(20, 0)) @(negedge clock);
                link.ack_toggle = ard_last_req;
            end
        end
    end

    initial begin : monitor
        mon_prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (tof_valid && !mon_prev_valid) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got tof_value %0h, expected no result", tof_value);
                end else begin
                    mon_exp = sb.pop_front();
                    check("tof_value",    32'(tof_value),    32'(mon_exp[CNT_W-1:0]));
                    check("timeout_flag", 32'(timeout_flag), 32'(mon_exp[CNT_W]));
                    check("serial_word",  32'(word_rx),      32'(mon_exp[CNT_W-1:0]));
                    check("bit_count",    32'(rx_count),     32'(CNT_W));
                    check("led_echo",     32'(led_echo),     32'(!mon_exp[CNT_W]));
                    check("led_holdoff",  32'(led_holdoff),  32'd1);
                    check("led_sent",     32'(led_sent),     32'd1);
                    check("busy_done",    32'(busy),         32'd0);
                end
            end
            mon_prev_valid = tof_valid;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
    endtask

    // Falls at k=0, k=extra (if nonzero) and k=interval; each low for 2 cycles.
    task automatic drive_tx(input int interval, input int extra);
        for (int k = 0; k <= interval + 1; k++) begin
            tx_n = !((k < 2) || (extra != 0 && k >= extra && k < extra + 2) ||
                     (k >= interval && k < interval + 2));
            tick(1);
        end
        tx_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int k;
        for (k = 0; k < max_cycles && !tof_valid; k++) tick(1);
        if (!tof_valid) begin
            n_total++;
            $display("FAIL %s: tof_valid still %0b after %0d cycles, expected 1", name, tof_valid, max_cycles);
        end
        tick(2);
    endtask

    task automatic measure(input string name, input int interval, input int extra);
        sb.push_back({1'b0, CNT_W'(interval)});
        pulse_start();
        drive_tx(interval, extra);
        wait_valid(name, 2000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},       32'(link.req_toggle), 32'd0);
        check({tag, "_data_bit"},  32'(link.data_bit),   32'd0);
        check({tag, "_tof_value"}, 32'(tof_value),       32'd0);
        check({tag, "_tof_valid"}, 32'(tof_valid),       32'd0);
        check({tag, "_timeout"},   32'(timeout_flag),    32'd0);
        check({tag, "_busy"},      32'(busy),            32'd0);
        check({tag, "_leds"},      32'({led_armed, led_holdoff, led_echo, led_sent}), 32'd0);
    endtask

    initial begin : stimulus
        logic req_before;
        int   k;
        reset_n = 1'b0;
        start   = 1'b0;
        tx_n    = 1'b1;
        abort   = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        check_reset_outputs("reset");

        measure("basic_40", 40, 0);
        measure("ignore_inside_holdoff", 30, 5);
        measure("min_result", HOLDOFF + 1, 0);
        measure("ignore_at_expiry", 20, HOLDOFF);

`ifdef TOF_TIMEOUT_EN
        sb.push_back({1'b1, {CNT_W{1'b1}}});
        pulse_start();
        drive_tx(1, 0);
        wait_valid("timeout", 2000);
`else
        pulse_start();
        tx_n = 1'b0;
        tick(2);
        tx_n = 1'b1;
        tick(1000);
        check("no_timeout_busy",    32'(busy),         32'd1);
        check("no_timeout_valid",   32'(tof_valid),    32'd0);
        check("no_timeout_holdoff", 32'(led_holdoff),  32'd1);
        check("no_timeout_armed",   32'(led_armed),    32'd1);
        check("no_timeout_flag",    32'(timeout_flag), 32'd0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("no_timeout_abort_busy", 32'(busy), 32'd0);
        tick(2);
`endif

        // abort during SEND after bit 7
        pulse_start();
        drive_tx(50, 0);
        for (k = 0; k < 1000 && rx_count < 8; k++) tick(1);
        if (rx_count < 8) begin
            n_total++;
            $display("FAIL abort_wait: got %0d bits, expected 8", rx_count);
        end
        req_before = link.req_toggle;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy",      32'(busy),            32'd0);
        check("abort_req_level", 32'(link.req_toggle), 32'(req_before));
        check("abort_tof_value", 32'(tof_value),       32'd0);
        check("abort_leds",      32'({led_armed, led_holdoff, led_echo, led_sent}), 32'd0);
        check("abort_data_bit",  32'(link.data_bit),   32'd0);
        tick(25);
        measure("after_abort", 12, 0);

        // reset for one cycle in the middle of the hold-off
        pulse_start();
        tx_n = 1'b0;
        tick(2);
        tx_n = 1'b1;
        tick(4);
        check("holdoff_busy",  32'(busy),        32'd1);
        check("holdoff_led",   32'(led_holdoff), 32'd0);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check_reset_outputs("midreset");
        tick(5);
        check("midreset_idle", 32'(busy), 32'd0);
        tick(25);
        measure("after_reset", 17, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #(90000 * 10);
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/tof_serial_timer.md
# tof_serial_timer

Parametrised time-of-flight timer for the LoRa ranging link. Arms on command, times the interval between the local transmit falling edge and the echo falling edge on the LoRa TX line, and ignores the line during a configurable hold-off. Shifts the result to the Arduino over the two-wire toggle handshake. Replaces the fixed 32-bit, level-triggered timer: adds edge detection, input synchronisers, saturation, status outputs and an optional echo timeout.

## Interface
- CNT_W, 32: width of the TOF counter and of the serial word.
- HOLDOFF, 10000000: cycles after the first edge during which TX edges are ignored; must be ≥1.
- TIMEOUT, 50000000: cycle count at which a missing echo is declared; used only with TOF_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, Basys board clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- start  in  1  arm request, sampled in IDLE only (ButtonDown).
- tx_n  in  1  LoRa TX line, active-low, asynchronous.
- ack_toggle  in  1  Arduino acknowledge toggle, asynchronous.
- abort  in  1  Arduino reset line, active-high; return to IDLE from any state.
- req_toggle  out  1  data-valid toggle to the Arduino.
- data_bit  out  1  serial data to the Arduino, LSB first.
- tof_value  out  CNT_W  captured count.
- tof_valid  out  1  high in DONE.
- timeout_flag  out  1  last result was a timeout.
- busy  out  1  high in every state except IDLE and DONE.
- led_armed, led_holdoff, led_echo, led_sent  out  1 each  status LEDs (ARM/COUNT active, hold-off expired, echo captured, word sent).

## Operation
- tx_n and ack_toggle each pass through a 2-flop synchroniser; the tx_n sync resets to 1 and ack_toggle's to 0. A falling edge means synchronised tx_n was 1 in the previous cycle and is 0 now.
- States: IDLE → ARM → HOLDOFF → WAIT_ECHO → SEND → DONE.
- IDLE: on start=1, clear the counter, tof_value and flags, then go to ARM.
- ARM: on a tx_n falling edge, set the counter to 0 and go to HOLDOFF.
- HOLDOFF: counter+1 every cycle; holdoff counter decrements from HOLDOFF. Reaching 0 sets led_holdoff and moves to WAIT_ECHO. Edges are ignored.
- WAIT_ECHO: counter+1 every cycle. On a falling edge, tof_value ← counter, set led_echo, go to SEND.
- Counter arithmetic is unsigned CNT_W and saturates at all-ones; it never wraps.
- SEND: on entry, drive data_bit=tof_value[0] and toggle req_toggle. When synchronised ack equals req_toggle, drive the next bit and toggle again. After CNT_W bits, go to DONE once the last bit is acked (ack==req).
- DONE: tof_valid=1 and led_sent=1. Hold until start re-arms (to ARM via the IDLE clearing) or abort.
- abort=1 in any state: go to IDLE next cycle. Clear all outputs except req_toggle, which keeps its level so the handshake stays in phase; abort takes priority over every other event.
- reset_n=0: all registers go to their reset values, including req_toggle=0.

## Timing
- Reset values: req_toggle=0, data_bit=0, tof_value=0, tof_valid=0, timeout_flag=0, busy=0, all LEDs 0, state IDLE.
- Edge-detect latency is 3 cycles from a pin transition. Both edges see the same latency, so the measured count equals the pin-to-pin interval in cycles.
- The echo edge must be no earlier than HOLDOFF+1 cycles after the first edge. Minimum result is HOLDOFF+1.
- An echo edge in the same cycle as the holdoff expiry is ignored; it is not latched.
- Per bit: ack match to new req_toggle is 1 cycle after synchronised match, 3 cycles after the pin.
- SEND: data_bit is stable from the req_toggle edge until the next toggle.

## Configuration
- TOF_TIMEOUT_EN defined: in WAIT_ECHO, if the counter equals TIMEOUT with no echo, set tof_value to all-ones and timeout_flag=1, then go to SEND, so the all-ones word is still shifted out.
- Undefined: no timeout. WAIT_ECHO persists until an echo or abort; timeout_flag is tied to 0.

## Test plan
- CNT_W=16, HOLDOFF=8: arm, tx_n falls at t0 and again at t0+40 → tof_value=40, 16 bits LSB-first on data_bit, tof_valid=1.
- Second tx_n fall at t0+5 (inside hold-off), then at t0+30 → the first is ignored, tof_value=30.
- Arduino ack delayed 0–20 random cycles per bit → 16 req_toggle toggles, word reconstructs exactly, no bit skipped or repeated.
- TOF_TIMEOUT_EN, TIMEOUT=100, no echo → tof_value=16'hFFFF, timeout_flag=1, word sent. Without the macro → still in WAIT_ECHO at cycle 1000.
- abort pulsed during SEND after bit 7 → IDLE next cycle, busy=0, req_toggle level retained; a re-arm completes a full measurement.
- reset_n low for 1 cycle mid-HOLDOFF → all outputs at reset values the next cycle, state IDLE.
